// File: rtl/bp_be_late_wb_arbiter_pkg.sv
// Shared BE types for the late writeback path: entry layout and the lock state.
package bp_be_late_wb_arbiter_pkg;

   localparam int data_width_p     = 64;
   localparam int reg_addr_width_p = 5;
   localparam int fflags_width_lp  = 5;
   localparam int starve_cnt_width_lp = 4;

   typedef struct packed {
      logic [reg_addr_width_p-1:0] rd_addr;
      logic                        fp;
      logic [data_width_p-1:0]     data;
      logic [fflags_width_lp-1:0]  fflags;
   } bp_be_late_wb_entry_s;

   typedef enum logic {
      e_lock_idle,
      e_lock_held
   } bp_be_late_wb_lock_e;

endpackage

// File: rtl/bp_be_late_wb_arbiter_if.sv
// Request side (per-requester valid/ready + payload) and late writeback port bundle.
interface bp_be_late_wb_arbiter_if #(parameter int num_req_p = 2);
   import bp_be_late_wb_arbiter_pkg::*;

   localparam int src_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

   logic [num_req_p-1:0]                  req_v_i;
   logic [num_req_p-1:0]                  req_ready_and_o;
   logic [num_req_p*reg_addr_width_p-1:0] req_rd_addr_i;
   logic [num_req_p-1:0]                  req_fp_i;
   logic [num_req_p*data_width_p-1:0]     req_data_i;
   logic [num_req_p*fflags_width_lp-1:0]  req_fflags_i;

   logic                                  wb_v_o;
   logic                                  wb_yumi_i;
   logic [reg_addr_width_p-1:0]           wb_rd_addr_o;
   logic                                  wb_fp_o;
   logic [data_width_p-1:0]               wb_data_o;
   logic [fflags_width_lp-1:0]            wb_fflags_o;
   logic [src_width_lp-1:0]               wb_src_o;
   logic                                  pending_o;

   // master: long-latency sources and writeback stage; slave: the arbiter
   modport master (
      output req_v_i, req_rd_addr_i, req_fp_i, req_data_i, req_fflags_i, wb_yumi_i,
      input  req_ready_and_o, wb_v_o, wb_rd_addr_o, wb_fp_o, wb_data_o, wb_fflags_o,
             wb_src_o, pending_o
   );

   modport slave (
      input  req_v_i, req_rd_addr_i, req_fp_i, req_data_i, req_fflags_i, wb_yumi_i,
      output req_ready_and_o, wb_v_o, wb_rd_addr_o, wb_fp_o, wb_data_o, wb_fflags_o,
             wb_src_o, pending_o
   );

endinterface

// File: rtl/bp_be_late_wb_slot.sv
// One-entry holding buffer: set wins over clear so a same-cycle refill stays full.
module bp_be_late_wb_slot
   import bp_be_late_wb_arbiter_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 set_i,
   input  logic                 clear_i,
   input  bp_be_late_wb_entry_s entry_i,
   output logic                 full_o,
   output bp_be_late_wb_entry_s entry_o
);

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (reset_i)      full_o <= 1'b0;
      else if (set_i)   full_o <= 1'b1;
      else if (clear_i) full_o <= 1'b0;
   end

   // NOTE: payload has no reset; it is only observed while full_o is set.
   always_ff @(posedge clk_i) begin
      if (set_i) entry_o <= entry_i;
   end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Late writeback arbiter: per-source slots, fixed priority with anti-starvation, grant lock until yumi.
module bp_be_late_wb_arbiter
   import bp_be_late_wb_arbiter_pkg::*;
#(
   parameter int num_req_p      = 2,
   parameter int starve_limit_p = 4
) (
   input logic                    clk_i,
   input logic                    reset_i,
   bp_be_late_wb_arbiter_if.slave io
);

   localparam int src_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam logic [starve_cnt_width_lp-1:0] starve_limit_lp = starve_cnt_width_lp'(starve_limit_p);
   typedef logic [src_width_lp-1:0] idx_t;

   bp_be_late_wb_entry_s slot_in  [num_req_p];
   bp_be_late_wb_entry_s slot_out [num_req_p];
   bp_be_late_wb_entry_s wb_entry;
   logic [num_req_p-1:0] full, ready, set, clear;

   bp_be_late_wb_lock_e state_q, state_n;
   idx_t lock_idx_q, lock_idx_n, last_grant_q, last_grant_n, sel_idx, grant;
   logic lock_forced_q, lock_forced_n, sel_forced, forced;
   logic [starve_cnt_width_lp-1:0] starve_q, starve_n;
   logic wb_v, yumi, higher_waiting;

   assign wb_v = |full;
   assign yumi = io.wb_yumi_i & wb_v;

   for (genvar i = 0; i < num_req_p; i++) begin : g_slot
      assign slot_in[i] = '{
         rd_addr: io.req_rd_addr_i[i*reg_addr_width_p +: reg_addr_width_p],
         fp:      io.req_fp_i[i],
         data:    io.req_data_i[i*data_width_p +: data_width_p],
         fflags:  io.req_fflags_i[i*fflags_width_lp +: fflags_width_lp]
      };
      assign clear[i] = yumi & (grant == idx_t'(i));
      // yumi->ready is combinational so a slot can drain and refill every cycle
      assign ready[i] = ~reset_i & (~full[i] | clear[i]);
      assign set[i]   = io.req_v_i[i] & ready[i];

      bp_be_late_wb_slot slot (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .set_i   (set[i]),
         .clear_i (clear[i]),
         .entry_i (slot_in[i]),
         .full_o  (full[i]),
         .entry_o (slot_out[i])
      );
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      sel_idx    = '0;
      sel_forced = 1'b0;
      for (int j = num_req_p-1; j >= 0; j--)
         if (full[j]) sel_idx = idx_t'(j);
      if (starve_q == starve_limit_lp) begin
         for (int j = num_req_p-1; j >= 0; j--)
            if (full[j] && (j > int'(last_grant_q))) begin
               sel_idx    = idx_t'(j);
               sel_forced = 1'b1;
            end
      end
   end

   assign grant  = (state_q == e_lock_held) ? lock_idx_q    : sel_idx;
   assign forced = (state_q == e_lock_held) ? lock_forced_q : sel_forced;

   always_comb begin
      higher_waiting = 1'b0;
      for (int j = 0; j < num_req_p; j++)
         if (full[j] && (j > int'(grant))) higher_waiting = 1'b1;
   end

   always_comb begin
      state_n       = state_q;
      lock_idx_n    = lock_idx_q;
      lock_forced_n = lock_forced_q;
      last_grant_n  = last_grant_q;
      starve_n      = starve_q;
      unique case (state_q)
         e_lock_idle: if (wb_v && !yumi) begin
            state_n       = e_lock_held;
            lock_idx_n    = grant;
            lock_forced_n = forced;
         end
         e_lock_held: if (yumi) state_n = e_lock_idle;
         default: state_n = e_lock_idle;
      endcase
      if (yumi) begin
         last_grant_n = grant;
         if (forced || !higher_waiting)        starve_n = '0;
         else if (starve_q != starve_limit_lp) starve_n = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= e_lock_idle;
         lock_idx_q    <= '0;
         lock_forced_q <= 1'b0;
         last_grant_q  <= '0;
         starve_q      <= '0;
      end else begin
         state_q       <= state_n;
         lock_idx_q    <= lock_idx_n;
         lock_forced_q <= lock_forced_n;
         last_grant_q  <= last_grant_n;
         starve_q      <= starve_n;
      end
   end

   assign wb_entry           = wb_v ? slot_out[grant] : '0;
   assign io.req_ready_and_o = ready;
   assign io.wb_v_o          = wb_v;
   assign io.pending_o       = wb_v;
   assign io.wb_rd_addr_o    = wb_entry.rd_addr;
   assign io.wb_fp_o         = wb_entry.fp;
   assign io.wb_data_o       = wb_entry.data;
   assign io.wb_fflags_o     = wb_entry.fflags;
   assign io.wb_src_o        = wb_v ? grant : '0;

endmodule
